// File: rtl/rv32i_types_pkg.sv
// Shared RV32I front-end types: machine word plus the branch predictor
// counter and sweep-state encodings.
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    // 2-bit saturating direction counter; the MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef enum logic {
        BP_IDLE  = 1'b0,
        BP_SWEEP = 1'b1
    } bp_state_t;

endpackage

// File: rtl/predictor_if.sv
// Fetch-side prediction and execute-side resolution signals of the BTB.
interface predictor_if;
    import rv32i_types_pkg::*;

    word_t fetch_pc;
    logic  predict_taken;
    word_t predict_target;

    logic  update_valid;
    word_t update_pc;
    logic  update_taken;
    word_t update_target;

    modport fetch (
        output fetch_pc,
        input  predict_taken,
        input  predict_target
    );

    modport update (
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target
    );

    modport predictor (
        input  fetch_pc,
        output predict_taken,
        output predict_target,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target
    );

endinterface

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import rv32i_types_pkg::*;
(
    input  bp_ctr_t ctr,
    input  logic    taken,
    output bp_ctr_t ctr_next
);

    function automatic bp_ctr_t sat_step(input bp_ctr_t c, input logic t);
        bp_ctr_t r;
        r = c;
        case (c)
            SNT:     r = t ? WNT : SNT;
            WNT:     r = t ? WT  : SNT;
            WT:      r = t ? ST  : WNT;
            ST:      r = t ? ST  : WT;
            default: r = c;
        endcase
        return r;
    endfunction

    assign ctr_next = sat_step(ctr, taken);

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Prediction is combinational from stored state; resolutions update the
// table one cycle later; a fence.i request sweeps all valid bits clear.
module branch_predictor_btb
    import rv32i_types_pkg::*;
#(
    parameter int NENTRIES = 16
)(
    input  logic                  CLK,
    input  logic                  RST,
    predictor_if.predictor        bp,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NENTRIES - 1);

    // Only valid bits and control are reset; tag/target/ctr are don't-care
    // while their entry is invalid.
    logic             valid_q  [NENTRIES];
    logic [TAG_W-1:0] tag_q    [NENTRIES];
    word_t            target_q [NENTRIES];
    bp_ctr_t          ctr_q    [NENTRIES];

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, u_en, u_alloc, pred_taken;
    bp_ctr_t          f_ctr, u_ctr_next;

    // Byte offset within the word never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.fetch_pc[1:0], bp.update_pc[1:0]};

    assign f_idx = bp.fetch_pc[IDX_W+1:2];
    assign f_tag = bp.fetch_pc[31:IDX_W+2];
    assign u_idx = bp.update_pc[IDX_W+1:2];
    assign u_tag = bp.update_pc[31:IDX_W+2];

    assign busy = (state_q == BP_SWEEP);

    // Prediction reads pre-update state: no bypass from a same-cycle update.
    assign f_ctr      = ctr_q[f_idx];
    assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken = f_hit && ((f_ctr == WT) || (f_ctr == ST)) && !busy;

    assign bp.predict_taken  = pred_taken;
    assign bp.predict_target = pred_taken ? target_q[f_idx] : '0;

    // Resolutions arriving during a sweep are discarded.
    assign u_en    = bp.update_valid && !busy;
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_alloc = u_en && !u_hit && bp.update_taken;

    sat_counter2 u_sat (
        .ctr      (ctr_q[u_idx]),
        .taken    (bp.update_taken),
        .ctr_next (u_ctr_next)
    );

    // Sweep FSM state and pointer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= BP_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Sweep FSM next state: one entry per cycle, ignoring repeat requests
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            BP_IDLE: begin
                if (clear_req) begin
                    state_d = BP_SWEEP;
                    ptr_d   = '0;
                end
            end
            BP_SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = BP_IDLE;
                end
            end
            default: state_d = BP_IDLE;
        endcase
    end

    // Valid bits: reset clears all at once, sweep clears one, allocate sets
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (busy) begin
            valid_q[ptr_q] <= 1'b0;
        end else if (u_alloc) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    // Entry payload: train counter on hit, replace entry on taken miss
    always_ff @(posedge CLK) begin
        if (!RST && u_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= u_ctr_next;
                if (bp.update_taken) begin
                    target_q[u_idx] <= bp.update_target;
                end
            end else if (bp.update_taken) begin
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= bp.update_target;
                ctr_q[u_idx]    <= WT;
            end
        end
    end

endmodule
